mem_bus_ctrl: RTL and testbench
===============================

Name: mem_bus_ctrl

Overview:
Arbitrated memory bus controller between the processor's requesters and the program ROM and data RAM.
- Requesters: instruction fetch from the control unit and load/store from the datapath; generalised to NUM_MASTERS.
- Decodes each address to the ROM or RAM region and inserts per-region wait states.
- Aligns sub-word data, and reports unmapped, misaligned or ROM-write accesses as faults instead of driving a shared data bus.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 64, bus width; power of two, at least 16.
- NUM_MASTERS, 2, number of requesters; master 0 is fetch.
- ROM_BASE, 32'h0000_0000, ROM region base; aligned to its size.
- ROM_AW, 12, log2 of ROM region size in bytes.
- RAM_BASE, 32'h0001_0000, RAM region base; aligned to its size.
- RAM_AW, 14, log2 of RAM region size in bytes.
- ROM_WAIT, 1, ROM access cycles (at least 1).
- RAM_WAIT, 2, RAM access cycles (at least 1).

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- m_req  in  NUM_MASTERS  per-master request; held until m_done.
- m_we  in  NUM_MASTERS  1 = write.
- m_size  in  2*NUM_MASTERS  0 = byte, 1 = half, 2 = word, 3 = dword.
- m_addr  in  ADDR_WIDTH*NUM_MASTERS  byte addresses.
- m_wdata  in  DATA_WIDTH*NUM_MASTERS  right-justified write data.
- m_done  out  NUM_MASTERS  one-cycle completion pulse to the granted master.
- m_fault  out  1  valid with m_done; access was rejected.
- m_rdata  out  DATA_WIDTH  right-justified, zero-extended read data; valid with m_done.
- ram_cs, ram_we, ram_oe  out  1 each  RAM strobes.
- ram_addr  out  RAM_AW  region offset, lane-aligned.
- ram_wdata  out  DATA_WIDTH  lane-shifted write data.
- ram_be  out  DATA_WIDTH/8  byte enables.
- ram_rdata  in  DATA_WIDTH  RAM read data.
- rom_cs, rom_oe  out  1 each  ROM strobes.
- rom_addr  out  ROM_AW  region offset, lane-aligned.
- rom_rdata  in  DATA_WIDTH  ROM read data.

Behaviour:
- Reset values: FSM = IDLE; all m_done, m_fault, cs/oe/we and be = 0; m_rdata = 0; rr_last = NUM_MASTERS-1 (so master 0 wins first).
- IDLE: if any m_req is high, grant round-robin starting at rr_last+1.
  - Latch addr, we, size and wdata of the granted master; update rr_last.
  - Decode in the same cycle.
- Fault conditions: size is 3 and DATA_WIDTH < 64; address not a multiple of 2^size; address in neither region; write to ROM.
  - On fault go to RESP with fault = 1; no cs is ever asserted.
- Otherwise go to ACCESS and load wait_cnt with the region WAIT-1.
- ACCESS: region cs held high every cycle.
  - oe = !we. we is asserted on ram_we for all RAM_WAIT cycles.
  - be = ((1<<2^size)-1) << lane, where lane = addr[log2(DATA_WIDTH/8)-1:0].
  - wdata is shifted left by lane*8.
  - When wait_cnt == 0: capture rdata >> lane*8, masked to 2^size bytes, then go to RESP. Otherwise decrement wait_cnt.
- RESP: m_done[grant] = 1 for exactly one cycle; m_fault and m_rdata are valid in that cycle.
  - m_rdata holds its value until the next RESP. Write responses return rdata = 0.
  - Go to IDLE. A new grant can start the following cycle, so there is no back-to-back bypass.
- Latency: request first seen high in IDLE at cycle T gives m_done at T+1+WAIT. A fault gives m_done at T+1.
- A master deasserting m_req after grant is ignored: the access completes and the done pulse is still issued. Requests are never cancelled.
- Simultaneous requests: exactly one grant per IDLE cycle. A losing master keeps m_req high and is served next (starvation-free).
- Reset during ACCESS or RESP: next cycle FSM = IDLE, strobes low, no m_done. The interrupted write may be partially applied; this is acceptable.
- Region offset = addr - base, truncated to the region AW. Both regions live in the same ADDR_WIDTH space; a region overlap is a configuration error and is not checked.

Decomposition:
- Shared package mem_bus_pkg:
  - size encodings (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_DWORD);
  - FSM state typedef (IDLE, ACCESS, RESP);
  - region select typedef (REG_NONE, REG_ROM, REG_RAM).
- Sub-module rr_arbiter (parameter N): request vector plus advance strobe, producing a one-hot grant and a grant index. Reused later by other multi-requester blocks.
- Lane shift, byte-enable generation and decode stay in mem_bus_ctrl.

Test Plan:
- Reset, then master 0 issues a dword read at 0x0000_0010 (ROM_WAIT = 1) → rom_cs high for 1 cycle; m_done[0] at T+2; m_rdata = rom_rdata; m_fault = 0.
- Master 1 issues a byte write of 0xAB to 0x0001_0005 → ram_cs and ram_we high for 2 cycles; ram_be = 8'b0010_0000; ram_wdata[47:40] = 0xAB; ram_addr = 0x0005 & ~7 = 0x0000; m_done[1] at T+3.
- Master 1 issues a half read at 0x0001_0006 with ram_rdata = 0x1122_3344_5566_7788 → m_rdata = 0x0000_0000_0000_1122.
- Both masters request in the same cycle, repeatedly → grants alternate 0, 1, 0, 1; each m_done is a single pulse; no cycle has two m_done bits high.
- Fault cases: word read at 0x0001_0002 (misaligned), read at 0x8000_0000 (unmapped), write to 0x0000_0000 (ROM) → each gives m_done at T+1 with m_fault = 1 and no cs asserted.
- Assert reset mid-ACCESS of a RAM read → the next cycle has all strobes 0, no m_done, FSM in IDLE; a request issued afterwards completes normally.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared types and helpers for the memory bus controller: size codes, FSM states,
// region selects and per-size mask generation.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'd0,
    SZ_HALF  = 2'd1,
    SZ_WORD  = 2'd2,
    SZ_DWORD = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    REG_NONE = 2'd0,
    REG_ROM  = 2'd1,
    REG_RAM  = 2'd2
  } region_e;

  // Low address bits that must be zero for a naturally aligned access
  function automatic logic [2:0] align_mask(input logic [1:0] size);
    case (size)
      SZ_BYTE: align_mask = 3'b000;
      SZ_HALF: align_mask = 3'b001;
      SZ_WORD: align_mask = 3'b011;
      default: align_mask = 3'b111;
    endcase
  endfunction

  // Right-justified byte-enable pattern covering 2^size bytes
  function automatic logic [7:0] size_be(input logic [1:0] size);
    case (size)
      SZ_BYTE: size_be = 8'h01;
      SZ_HALF: size_be = 8'h03;
      SZ_WORD: size_be = 8'h0F;
      default: size_be = 8'hFF;
    endcase
  endfunction

  // Right-justified data mask covering 2^size bytes
  function automatic logic [63:0] size_dmask(input logic [1:0] size);
    case (size)
      SZ_BYTE: size_dmask = 64'h0000_0000_0000_00FF;
      SZ_HALF: size_dmask = 64'h0000_0000_0000_FFFF;
      SZ_WORD: size_dmask = 64'h0000_0000_FFFF_FFFF;
      default: size_dmask = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

endpackage

// File: rtl/mem_bus_ctrl_rr_arbiter.sv
// Round-robin arbiter: one-hot grant and index, priority rotating from the last winner.
module rr_arbiter #(
  parameter int unsigned N = 2,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  grant_c,
  output logic [IW-1:0] grant_idx_c
);

  logic [IW-1:0] rr_last_q;
  logic          found;
  int unsigned   idx;

  // Search starts one past the previous winner so every requester is served in turn
  always_comb begin
    grant_c     = '0;
    grant_idx_c = '0;
    found       = 1'b0;
    idx         = 0;
    for (int unsigned i = 1; i <= N; i++) begin
      idx = (32'(rr_last_q) + i) % N;
      if (!found && req[IW'(idx)]) begin
        found              = 1'b1;
        grant_c[IW'(idx)]  = 1'b1;
        grant_idx_c        = IW'(idx);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_last_q <= IW'(N - 1);
    end else if (advance && found) begin
      rr_last_q <= grant_idx_c;
    end
  end

endmodule

// File: rtl/mem_bus_ctrl.sv
// Arbitrated ROM/RAM bus controller: grants one master at a time, decodes the region,
// inserts per-region wait states, lane-aligns sub-word data and reports faults.
module mem_bus_ctrl
  import mem_bus_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           DATA_WIDTH  = 64,
  parameter int unsigned           NUM_MASTERS = 2,
  parameter logic [ADDR_WIDTH-1:0] ROM_BASE    = 32'h0000_0000,
  parameter int unsigned           ROM_AW      = 12,
  parameter logic [ADDR_WIDTH-1:0] RAM_BASE    = 32'h0001_0000,
  parameter int unsigned           RAM_AW      = 14,
  parameter int unsigned           ROM_WAIT    = 1,
  parameter int unsigned           RAM_WAIT    = 2
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [NUM_MASTERS-1:0]            m_req,
  input  logic [NUM_MASTERS-1:0]            m_we,
  input  logic [2*NUM_MASTERS-1:0]          m_size,
  input  logic [ADDR_WIDTH*NUM_MASTERS-1:0] m_addr,
  input  logic [DATA_WIDTH*NUM_MASTERS-1:0] m_wdata,
  output logic [NUM_MASTERS-1:0]            m_done,
  output logic                              m_fault,
  output logic [DATA_WIDTH-1:0]             m_rdata,
  output logic                              ram_cs,
  output logic                              ram_we,
  output logic                              ram_oe,
  output logic [RAM_AW-1:0]                 ram_addr,
  output logic [DATA_WIDTH-1:0]             ram_wdata,
  output logic [DATA_WIDTH/8-1:0]           ram_be,
  input  logic [DATA_WIDTH-1:0]             ram_rdata,
  output logic                              rom_cs,
  output logic                              rom_oe,
  output logic [ROM_AW-1:0]                 rom_addr,
  input  logic [DATA_WIDTH-1:0]             rom_rdata
);

  localparam int unsigned BE_W     = DATA_WIDTH / 8;
  localparam int unsigned LANE_W   = $clog2(BE_W);
  localparam int unsigned MAX_WAIT = (ROM_WAIT > RAM_WAIT) ? ROM_WAIT : RAM_WAIT;
  localparam int unsigned WC_W     = $clog2(MAX_WAIT + 1);
  localparam int unsigned IW       = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  state_e                 state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_c;
  logic [IW-1:0]          grant_idx_c;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic                   we_q, we_d;
  logic [1:0]             size_q, size_d;
  logic [LANE_W-1:0]      lane_q, lane_d;
  region_e                region_q, region_d;
  logic [WC_W-1:0]        wait_q, wait_d;

  logic [ADDR_WIDTH-1:0]  sel_addr;
  logic                   sel_we;
  logic [1:0]             sel_size;
  logic [DATA_WIDTH-1:0]  sel_wdata;
  logic [LANE_W-1:0]      sel_lane;
  region_e                sel_region;
  logic                   sel_fault;
  logic                   rom_hit, ram_hit;
  logic [RAM_AW-1:0]      ram_off;
  logic [ROM_AW-1:0]      rom_off;
  logic [DATA_WIDTH-1:0]  rd_src, rd_aligned;

  logic [NUM_MASTERS-1:0] m_done_d;
  logic                   m_fault_d;
  logic [DATA_WIDTH-1:0]  m_rdata_d;
  logic                   ram_cs_d, ram_we_d, ram_oe_d;
  logic [RAM_AW-1:0]      ram_addr_d;
  logic [DATA_WIDTH-1:0]  ram_wdata_d;
  logic [BE_W-1:0]        ram_be_d;
  logic                   rom_cs_d, rom_oe_d;
  logic [ROM_AW-1:0]      rom_addr_d;

  rr_arbiter #(.N(NUM_MASTERS)) u_arb (
    .clock       (clock),
    .reset       (reset),
    .req         (m_req),
    .advance     (state_q == IDLE),
    .grant_c     (grant_c),
    .grant_idx_c (grant_idx_c)
  );

  // Request fields of the currently granted master
  always_comb begin
    sel_addr  = '0;
    sel_we    = 1'b0;
    sel_size  = '0;
    sel_wdata = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (grant_idx_c == IW'(i)) begin
        sel_addr  = m_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_we    = m_we[i];
        sel_size  = m_size[2*i +: 2];
        sel_wdata = m_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Region decode and fault classification of the granted request
  always_comb begin
    rom_hit    = ((sel_addr ^ ROM_BASE) >> ROM_AW) == '0;
    ram_hit    = ((sel_addr ^ RAM_BASE) >> RAM_AW) == '0;
    sel_region = rom_hit ? REG_ROM : (ram_hit ? REG_RAM : REG_NONE);
    sel_lane   = sel_addr[LANE_W-1:0];
    sel_fault  = ((sel_size == SZ_DWORD) && (DATA_WIDTH < 64))
              || ((sel_addr[2:0] & align_mask(sel_size)) != 3'b000)
              || (sel_region == REG_NONE)
              || ((sel_region == REG_ROM) && sel_we);
    ram_off    = sel_addr[RAM_AW-1:0] - RAM_BASE[RAM_AW-1:0];
    rom_off    = sel_addr[ROM_AW-1:0] - ROM_BASE[ROM_AW-1:0];
    rd_src     = (region_q == REG_ROM) ? rom_rdata : ram_rdata;
    rd_aligned = (rd_src >> {lane_q, 3'b000}) & DATA_WIDTH'(size_dmask(size_q));
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    we_d        = we_q;
    size_d      = size_q;
    lane_d      = lane_q;
    region_d    = region_q;
    wait_d      = wait_q;
    m_done_d    = '0;
    m_fault_d   = 1'b0;
    m_rdata_d   = m_rdata;
    ram_cs_d    = ram_cs;
    ram_we_d    = ram_we;
    ram_oe_d    = ram_oe;
    ram_addr_d  = ram_addr;
    ram_wdata_d = ram_wdata;
    ram_be_d    = ram_be;
    rom_cs_d    = rom_cs;
    rom_oe_d    = rom_oe;
    rom_addr_d  = rom_addr;
    case (state_q)
      IDLE: begin
        if (|m_req) begin
          grant_d  = grant_c;
          we_d     = sel_we;
          size_d   = sel_size;
          lane_d   = sel_lane;
          region_d = sel_region;
          if (sel_fault) begin
            state_d   = RESP;
            m_done_d  = grant_c;
            m_fault_d = 1'b1;
            m_rdata_d = '0;
          end else if (sel_region == REG_ROM) begin
            state_d    = ACCESS;
            wait_d     = WC_W'(ROM_WAIT - 1);
            rom_cs_d   = 1'b1;
            rom_oe_d   = 1'b1;
            rom_addr_d = rom_off & ~ROM_AW'(BE_W - 1);
          end else begin
            state_d     = ACCESS;
            wait_d      = WC_W'(RAM_WAIT - 1);
            ram_cs_d    = 1'b1;
            ram_we_d    = sel_we;
            ram_oe_d    = !sel_we;
            ram_be_d    = BE_W'(size_be(sel_size)) << sel_lane;
            ram_wdata_d = sel_wdata << {sel_lane, 3'b000};
            ram_addr_d  = ram_off & ~RAM_AW'(BE_W - 1);
          end
        end
      end
      ACCESS: begin
        if (wait_q == '0) begin
          state_d   = RESP;
          m_done_d  = grant_q;
          m_rdata_d = we_q ? '0 : rd_aligned;
          ram_cs_d  = 1'b0;
          ram_we_d  = 1'b0;
          ram_oe_d  = 1'b0;
          ram_be_d  = '0;
          rom_cs_d  = 1'b0;
          rom_oe_d  = 1'b0;
        end else begin
          wait_d = wait_q - WC_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      we_q      <= 1'b0;
      size_q    <= '0;
      lane_q    <= '0;
      region_q  <= REG_NONE;
      wait_q    <= '0;
      m_done    <= '0;
      m_fault   <= 1'b0;
      m_rdata   <= '0;
      ram_cs    <= 1'b0;
      ram_we    <= 1'b0;
      ram_oe    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      ram_be    <= '0;
      rom_cs    <= 1'b0;
      rom_oe    <= 1'b0;
      rom_addr  <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      we_q      <= we_d;
      size_q    <= size_d;
      lane_q    <= lane_d;
      region_q  <= region_d;
      wait_q    <= wait_d;
      m_done    <= m_done_d;
      m_fault   <= m_fault_d;
      m_rdata   <= m_rdata_d;
      ram_cs    <= ram_cs_d;
      ram_we    <= ram_we_d;
      ram_oe    <= ram_oe_d;
      ram_addr  <= ram_addr_d;
      ram_wdata <= ram_wdata_d;
      ram_be    <= ram_be_d;
      rom_cs    <= rom_cs_d;
      rom_oe    <= rom_oe_d;
      rom_addr  <= rom_addr_d;
    end
  end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl: vector table of single accesses plus round-robin
// and mid-access reset sequences.
module tb_mem_bus_ctrl;

  localparam int unsigned NM = 2;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 64;

  logic            clock;
  logic            reset;
  logic [NM-1:0]   m_req, m_we;
  logic [2*NM-1:0] m_size;
  logic [AW*NM-1:0] m_addr;
  logic [DW*NM-1:0] m_wdata;
  logic [NM-1:0]   m_done;
  logic            m_fault;
  logic [DW-1:0]   m_rdata;
  logic            ram_cs, ram_we, ram_oe;
  logic [13:0]     ram_addr;
  logic [DW-1:0]   ram_wdata;
  logic [7:0]      ram_be;
  logic [DW-1:0]   ram_rdata;
  logic            rom_cs, rom_oe;
  logic [11:0]     rom_addr;
  logic [DW-1:0]   rom_rdata;

  int tests = 0;
  int fails = 0;

  mem_bus_ctrl #(
    .ADDR_WIDTH(32), .DATA_WIDTH(64), .NUM_MASTERS(2),
    .ROM_BASE(32'h0000_0000), .ROM_AW(12),
    .RAM_BASE(32'h0001_0000), .RAM_AW(14),
    .ROM_WAIT(1), .RAM_WAIT(2)
  ) dut (
    .clock(clock), .reset(reset),
    .m_req(m_req), .m_we(m_we), .m_size(m_size), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_done(m_done), .m_fault(m_fault), .m_rdata(m_rdata),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_oe(ram_oe), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_be(ram_be), .ram_rdata(ram_rdata),
    .rom_cs(rom_cs), .rom_oe(rom_oe), .rom_addr(rom_addr), .rom_rdata(rom_rdata)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int          master;
    bit          we;
    bit [1:0]    size;
    bit [31:0]   addr;
    bit [63:0]   wdata;
    bit [63:0]   mem_rdata;
    bit          exp_fault;
    bit [63:0]   exp_rdata;
    int          exp_lat;
    int          exp_rom;
    int          exp_ram;
    bit [7:0]    exp_be;
    bit [31:0]   exp_maddr;
    bit [63:0]   exp_wdata;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(int master, bit we, bit [1:0] size, bit [31:0] addr,
                              bit [63:0] wdata, bit [63:0] mem, bit fault, bit [63:0] rdata,
                              int lat, int rom_n, int ram_n, bit [7:0] be,
                              bit [31:0] maddr, bit [63:0] exp_wd);
    vec_t v;
    v.master = master; v.we = we; v.size = size; v.addr = addr; v.wdata = wdata;
    v.mem_rdata = mem; v.exp_fault = fault; v.exp_rdata = rdata; v.exp_lat = lat;
    v.exp_rom = rom_n; v.exp_ram = ram_n; v.exp_be = be; v.exp_maddr = maddr;
    v.exp_wdata = exp_wd;
    return v;
  endfunction

  // One access from one master, requested at a negedge while the controller is idle
  task automatic run_vec(input int idx, input vec_t v);
    int lat, rom_n, ram_n, we_n, oe_n;
    logic [NM-1:0] done_v;
    logic          fault_v;
    logic [63:0]   rdata_v, wd_v;
    logic [7:0]    be_v;
    logic [31:0]   maddr_v;
    lat = -1; rom_n = 0; ram_n = 0; we_n = 0; oe_n = 0;
    done_v = '0; fault_v = 1'b0; rdata_v = '0; wd_v = '0; be_v = '0; maddr_v = '0;
    m_we[v.master]               = v.we;
    m_size[2*v.master +: 2]      = v.size;
    m_addr[v.master*AW +: AW]    = v.addr;
    m_wdata[v.master*DW +: DW]   = v.wdata;
    rom_rdata = v.mem_rdata;
    ram_rdata = v.mem_rdata;
    m_req[v.master] = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clock);
      if (ram_cs) begin
        ram_n++;
        if (ram_we) we_n++;
        if (ram_oe) oe_n++;
        be_v = ram_be; maddr_v = 32'(ram_addr); wd_v = ram_wdata;
      end
      if (rom_cs) begin
        rom_n++;
        if (rom_oe) oe_n++;
        maddr_v = 32'(rom_addr);
      end
      if (m_done != '0) begin
        lat = c; done_v = m_done; fault_v = m_fault; rdata_v = m_rdata;
        break;
      end
    end
    m_req[v.master] = 1'b0;
    check($sformatf("v%0d_latency", idx), 64'(lat), 64'(v.exp_lat));
    check($sformatf("v%0d_done", idx), 64'(done_v), 64'(1 << v.master));
    check($sformatf("v%0d_fault", idx), 64'(fault_v), 64'(v.exp_fault));
    check($sformatf("v%0d_rdata", idx), rdata_v, v.exp_rdata);
    check($sformatf("v%0d_rom_cycles", idx), 64'(rom_n), 64'(v.exp_rom));
    check($sformatf("v%0d_ram_cycles", idx), 64'(ram_n), 64'(v.exp_ram));
    if (v.exp_ram > 0) begin
      check($sformatf("v%0d_ram_be", idx), 64'(be_v), 64'(v.exp_be));
      check($sformatf("v%0d_ram_addr", idx), 64'(maddr_v), 64'(v.exp_maddr));
      check($sformatf("v%0d_ram_we_cycles", idx), 64'(we_n), 64'(v.we ? v.exp_ram : 0));
      check($sformatf("v%0d_ram_oe_cycles", idx), 64'(oe_n), 64'(v.we ? 0 : v.exp_ram));
      if (v.we) check($sformatf("v%0d_ram_wdata", idx), wd_v, v.exp_wdata);
    end
    if (v.exp_rom > 0) begin
      check($sformatf("v%0d_rom_addr", idx), 64'(maddr_v), 64'(v.exp_maddr));
      check($sformatf("v%0d_rom_oe_cycles", idx), 64'(oe_n), 64'(v.exp_rom));
    end
    @(negedge clock);
    check($sformatf("v%0d_done_single_pulse", idx), 64'(m_done), 64'(0));
    check($sformatf("v%0d_rdata_hold", idx), m_rdata, v.exp_rdata);
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    m_req = '0;
    repeat (cycles) @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    int order[4];
    int n_done, double_n, adjacent_n;
    logic [NM-1:0] prev_done;

    m_req = '0; m_we = '0; m_size = '0; m_addr = '0; m_wdata = '0;
    ram_rdata = '0; rom_rdata = '0; reset = 1'b1;

    //       mst we size addr           wdata                  mem_rdata              flt exp_rdata              lat rom ram be     maddr     exp_wdata
    vecs[0]  = mk(0, 0, 2'd3, 32'h0000_0010, 64'h0,                 64'h0123_4567_89AB_CDEF, 0, 64'h0123_4567_89AB_CDEF, 2, 1, 0, 8'h00, 32'h0010, 64'h0);
    vecs[1]  = mk(1, 1, 2'd0, 32'h0001_0005, 64'hAB,                64'h0,                   0, 64'h0,                   3, 0, 2, 8'h20, 32'h0000, 64'h0000_AB00_0000_0000);
    vecs[2]  = mk(1, 0, 2'd1, 32'h0001_0006, 64'h0,                 64'h1122_3344_5566_7788, 0, 64'h1122,                3, 0, 2, 8'hC0, 32'h0000, 64'h0);
    vecs[3]  = mk(0, 0, 2'd2, 32'h0001_0104, 64'h0,                 64'h1122_3344_5566_7788, 0, 64'h1122_3344,           3, 0, 2, 8'hF0, 32'h0100, 64'h0);
    vecs[4]  = mk(0, 0, 2'd0, 32'h0000_0FFF, 64'h0,                 64'hA500_0000_0000_0000, 0, 64'hA5,                  2, 1, 0, 8'h00, 32'h0FF8, 64'h0);
    vecs[5]  = mk(1, 1, 2'd3, 32'h0001_3FF8, 64'hDEAD_BEEF_CAFE_F00D, 64'h0,                 0, 64'h0,                   3, 0, 2, 8'hFF, 32'h3FF8, 64'hDEAD_BEEF_CAFE_F00D);
    vecs[6]  = mk(0, 0, 2'd2, 32'h0001_0002, 64'h0,                 64'hFFFF_FFFF_FFFF_FFFF, 1, 64'h0,                   1, 0, 0, 8'h00, 32'h0,    64'h0);
    vecs[7]  = mk(1, 0, 2'd3, 32'h8000_0000, 64'h0,                 64'hFFFF_FFFF_FFFF_FFFF, 1, 64'h0,                   1, 0, 0, 8'h00, 32'h0,    64'h0);
    vecs[8]  = mk(0, 1, 2'd0, 32'h0000_0000, 64'h55,                64'hFFFF_FFFF_FFFF_FFFF, 1, 64'h0,                   1, 0, 0, 8'h00, 32'h0,    64'h0);
    vecs[9]  = mk(1, 0, 2'd1, 32'h0001_0001, 64'h0,                 64'hFFFF_FFFF_FFFF_FFFF, 1, 64'h0,                   1, 0, 0, 8'h00, 32'h0,    64'h0);
    vecs[10] = mk(0, 0, 2'd0, 32'h0001_4000, 64'h0,                 64'hFFFF_FFFF_FFFF_FFFF, 1, 64'h0,                   1, 0, 0, 8'h00, 32'h0,    64'h0);
    vecs[11] = mk(1, 0, 2'd2, 32'h0000_1000, 64'h0,                 64'hFFFF_FFFF_FFFF_FFFF, 1, 64'h0,                   1, 0, 0, 8'h00, 32'h0,    64'h0);

    // Reset state
    do_reset(3);
    check("reset_done", 64'(m_done), 64'(0));
    check("reset_fault", 64'(m_fault), 64'(0));
    check("reset_rdata", m_rdata, 64'h0);
    check("reset_strobes", 64'({ram_cs, ram_we, ram_oe, rom_cs, rom_oe}), 64'(0));
    check("reset_be", 64'(ram_be), 64'(0));

    for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

    // Both masters requesting continuously after reset: master 0 first, then alternate
    do_reset(2);
    rom_rdata = 64'h0F0F_0F0F_0F0F_0F0F;
    m_we = '0;
    m_size = {2'd3, 2'd3};
    m_addr = {32'h0000_0020, 32'h0000_0008};
    m_req = 2'b11;
    n_done = 0; double_n = 0; adjacent_n = 0; prev_done = '0;
    for (int c = 0; c < 60 && n_done < 4; c++) begin
      @(negedge clock);
      if (m_done == 2'b11) double_n++;
      if ((m_done & prev_done) != '0) adjacent_n++;
      prev_done = m_done;
      if (m_done[0]) begin order[n_done] = 0; n_done++; end
      else if (m_done[1]) begin order[n_done] = 1; n_done++; end
    end
    m_req = '0;
    check("rr_done_count", 64'(n_done), 64'(4));
    for (int k = 0; k < 4; k++) begin
      if (k < n_done) check($sformatf("rr_grant%0d", k), 64'(order[k]), 64'(k % 2));
    end
    check("rr_double_done", 64'(double_n), 64'(0));
    check("rr_done_pulse_width", 64'(adjacent_n), 64'(0));
    @(negedge clock);
    @(negedge clock);

    // Reset in the middle of a RAM read
    m_we[1] = 1'b0;
    m_size[3:2] = 2'd3;
    m_addr[63:32] = 32'h0001_0008;
    ram_rdata = 64'hCAFE_CAFE_CAFE_CAFE;
    m_req[1] = 1'b1;
    @(negedge clock);
    check("midrst_ram_cs_before", 64'(ram_cs), 64'(1));
    reset = 1'b1;
    m_req = '0;
    @(negedge clock);
    check("midrst_strobes", 64'({ram_cs, ram_we, ram_oe, rom_cs, rom_oe}), 64'(0));
    check("midrst_be", 64'(ram_be), 64'(0));
    check("midrst_done", 64'(m_done), 64'(0));
    reset = 1'b0;
    @(negedge clock);
    check("midrst_done_after", 64'(m_done), 64'(0));
    run_vec(100, vecs[2]);
    run_vec(101, vecs[0]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
